// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EX pipeline.
// Produces per-stage write-enables and bubble flushes for load-use stalls,
// EX-resolved redirects, data-memory wait freezes and the multi-cycle EX
// unit handshake (with timeout), and keeps stall/flush performance counters.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_RUN     | normal flow; stalls/redirects resolved each cycle
// ST_MC_WAIT | multi-cycle op in flight; front frozen, EX/MEM bubbled
module pipeline_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_TIMEOUT     = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                      ex_MemRead_i,
  input  logic                      ex_redirect_i,
  input  logic                      ex_mc_valid_i,
  input  logic                      mc_done_i,
  input  logic                      mem_busy_i,
  output logic                      pc_we_o,
  output logic                      if_id_we_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_we_o,
  output logic                      id_ex_flush_o,
  output logic                      ex_mem_we_o,
  output logic                      ex_mem_flush_o,
  output logic                      mc_start_o,
  output logic                      mc_timeout_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  // Wait counter only has to reach MC_TIMEOUT-1.
  localparam int TW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(MC_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic                 done_pending_q, done_pending_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic rel;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    rs1_hit  = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit  = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
    load_use = ex_MemRead_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);
    // A done pulse that landed during a memory freeze is remembered in
    // done_pending_q so the release still happens on the first free cycle.
    rel      = mc_done_i || done_pending_q || (cnt_q == CNT_LAST);
  end

  // Stage control decode and next-state computation.
  always_comb begin
    pc_we_o        = 1'b0;
    if_id_we_o     = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_we_o     = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_we_o    = 1'b0;
    ex_mem_flush_o = 1'b0;
    mc_start_o     = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    done_pending_d = done_pending_q;
    timeout_d      = timeout_q;

    if (rst) begin
      // Outputs stay at the freeze pattern; registers reset in the flop block.
    end else if (mem_busy_i) begin
      if ((state_q == ST_MC_WAIT) && mc_done_i) begin
        done_pending_d = 1'b1;
      end
    end else if ((state_q == ST_RUN) && ex_mc_valid_i) begin
      mc_start_o     = 1'b1;
      ex_mem_we_o    = 1'b1;
      ex_mem_flush_o = 1'b1;
      state_d        = ST_MC_WAIT;
      cnt_d          = '0;
    end else if ((state_q == ST_MC_WAIT) && !rel) begin
      ex_mem_we_o    = 1'b1;
      ex_mem_flush_o = 1'b1;
      cnt_d          = cnt_q + TW'(1);
    end else begin
      // RUN without a new multi-cycle op, or the release cycle of MC_WAIT.
      // On release ex_mc_valid_i is ignored so the retiring op never restarts.
      if (state_q == ST_MC_WAIT) begin
        state_d        = ST_RUN;
        done_pending_d = 1'b0;
        if (!mc_done_i && !done_pending_q) begin
          timeout_d = 1'b1;
        end
      end
      if (ex_redirect_i) begin
        pc_we_o       = 1'b1;
        if_id_we_o    = 1'b1;
        id_ex_we_o    = 1'b1;
        ex_mem_we_o   = 1'b1;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (load_use) begin
        id_ex_we_o    = 1'b1;
        id_ex_flush_o = 1'b1;
        ex_mem_we_o   = 1'b1;
      end else begin
        pc_we_o     = 1'b1;
        if_id_we_o  = 1'b1;
        id_ex_we_o  = 1'b1;
        ex_mem_we_o = 1'b1;
      end
    end

    stall_cnt_d = pc_we_o       ? stall_cnt_q : stall_cnt_q + CNT_WIDTH'(1);
    flush_cnt_d = if_id_flush_o ? flush_cnt_q + CNT_WIDTH'(1) : flush_cnt_q;
  end

  // State, wait counter, sticky timeout and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      done_pending_q <= 1'b0;
      timeout_q      <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      done_pending_q <= done_pending_d;
      timeout_q      <= timeout_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign mc_timeout_o = timeout_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// random traffic, compared each cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int RAW = 5;
  localparam int TMO = 8;
  localparam int CW  = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [RAW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic           id_rs1_used, id_rs2_used, ex_MemRead, ex_redirect;
  logic           ex_mc_valid, mc_done, mem_busy;
  logic           pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic           ex_mem_we, ex_mem_flush, mc_start, mc_timeout;
  logic [CW-1:0]  stall_cnt, flush_cnt;

  pipeline_ctrl #(.REG_ADDR_WIDTH(RAW), .MC_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_rd_addr_i(ex_rd_addr), .ex_MemRead_i(ex_MemRead),
    .ex_redirect_i(ex_redirect), .ex_mc_valid_i(ex_mc_valid),
    .mc_done_i(mc_done), .mem_busy_i(mem_busy),
    .pc_we_o(pc_we), .if_id_we_o(if_id_we), .if_id_flush_o(if_id_flush),
    .id_ex_we_o(id_ex_we), .id_ex_flush_o(id_ex_flush),
    .ex_mem_we_o(ex_mem_we), .ex_mem_flush_o(ex_mem_flush),
    .mc_start_o(mc_start), .mc_timeout_o(mc_timeout),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: "busy with a multi-cycle op", cycles spent waiting,
  // remembered done, sticky timeout, event counters.
  bit        m_waiting;
  int        m_waited;
  bit        m_done_seen;
  bit        m_tmo;
  bit [31:0] m_stalls;
  bit [31:0] m_flushes;

  // Expected stage controls {pc, ifid, ifid_fl, idex, idex_fl, exmem, exmem_fl, start}
  bit [7:0]  e;

  localparam bit [7:0] P_FREEZE = 8'b0000_0000;
  localparam bit [7:0] P_START  = 8'b0000_0111;
  localparam bit [7:0] P_BUBBLE = 8'b0000_0110;
  localparam bit [7:0] P_REDIR  = 8'b1111_1100;
  localparam bit [7:0] P_LDUSE  = 8'b0001_1100;
  localparam bit [7:0] P_FLOW   = 8'b1101_0100;

  function automatic bit hazard();
    return ex_MemRead && ex_rd_addr != 0 &&
           ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
            (id_rs2_used && id_rs2_addr == ex_rd_addr));
  endfunction

  function automatic bit releasing();
    return mc_done || m_done_seen || (m_waited == TMO - 1);
  endfunction

  function automatic bit [7:0] expect_ctrl();
    if (rst || mem_busy)                 return P_FREEZE;
    if (!m_waiting && ex_mc_valid)       return P_START;
    if (m_waiting && !releasing())       return P_BUBBLE;
    if (ex_redirect)                     return P_REDIR;
    if (hazard())                        return P_LDUSE;
    return P_FLOW;
  endfunction

  task automatic model_clock();
    if (rst) begin
      m_waiting = 0; m_waited = 0; m_done_seen = 0; m_tmo = 0;
      m_stalls = 0; m_flushes = 0;
      return;
    end
    if (!e[7]) m_stalls++;
    if (e[5])  m_flushes++;
    if (mem_busy) begin
      if (m_waiting && mc_done) m_done_seen = 1;
    end else if (!m_waiting) begin
      if (ex_mc_valid) begin m_waiting = 1; m_waited = 0; end
    end else if (releasing()) begin
      if (!mc_done && !m_done_seen) m_tmo = 1;
      m_waiting = 0; m_done_seen = 0;
    end else begin
      m_waited++;
    end
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic step();
    #1;
    e = expect_ctrl();
    chk("pc_we",        pc_we,        e[7]);
    chk("if_id_we",     if_id_we,     e[6]);
    chk("if_id_flush",  if_id_flush,  e[5]);
    chk("id_ex_we",     id_ex_we,     e[4]);
    chk("id_ex_flush",  id_ex_flush,  e[3]);
    chk("ex_mem_we",    ex_mem_we,    e[2]);
    chk("ex_mem_flush", ex_mem_flush, e[1]);
    chk("mc_start",     mc_start,     e[0]);
    chk("mc_timeout",   mc_timeout,   m_tmo);
    chk("stall_cnt",    stall_cnt,    m_stalls);
    chk("flush_cnt",    flush_cnt,    m_flushes);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; ex_MemRead = 0; ex_redirect = 0;
    ex_mc_valid = 0; mc_done = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    idle_inputs();
    m_waiting = 0; m_waited = 0; m_done_seen = 0; m_tmo = 0;
    m_stalls = 0; m_flushes = 0;
    rst = 1;
    @(negedge clk);
    step(); step();
    rst = 0;
    repeat (3) step();

    // load-use on rs1, then same pattern with rd=0
    ex_MemRead = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_rs1_used = 1; step();
    idle_inputs(); step();
    chk("stall_after_lu", stall_cnt, 1);
    ex_MemRead = 1; ex_rd_addr = 0; id_rs1_addr = 0; id_rs1_used = 1; step();
    idle_inputs(); step();

    // redirect together with load-use
    do_reset();
    ex_MemRead = 1; ex_rd_addr = 7; id_rs2_addr = 7; id_rs2_used = 1;
    ex_redirect = 1; step();
    idle_inputs(); step();
    chk("flush_after_redir", flush_cnt, 1);
    chk("stall_after_redir", stall_cnt, 0);

    // multi-cycle op, done after 4 waiting cycles
    ex_mc_valid = 1; step();
    repeat (4) step();
    mc_done = 1; step();
    idle_inputs(); repeat (2) step();

    // done lands during a memory freeze
    ex_mc_valid = 1; step();
    repeat (2) step();
    mem_busy = 1; mc_done = 1; step();
    mc_done = 0; mem_busy = 0; step();
    idle_inputs(); repeat (2) step();

    // timeout: done never arrives
    ex_mc_valid = 1; step();
    repeat (TMO) step();
    idle_inputs(); repeat (3) step();
    chk("tmo_sticky", mc_timeout, 1);
    do_reset();
    step();

    // reset in the middle of a wait
    ex_mc_valid = 1; step();
    repeat (2) step();
    rst = 1; step();
    rst = 0; repeat (3) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      id_rs1_addr = RAW'($urandom_range(0, 3));
      id_rs2_addr = RAW'($urandom_range(0, 3));
      ex_rd_addr  = RAW'($urandom_range(0, 3));
      id_rs1_used = $urandom_range(0, 1) == 1;
      id_rs2_used = $urandom_range(0, 1) == 1;
      ex_MemRead  = $urandom_range(0, 2) == 0;
      ex_mc_valid = $urandom_range(0, 7) == 0;
      ex_redirect = !ex_mc_valid && ($urandom_range(0, 5) == 0);
      mc_done     = $urandom_range(0, 9) == 0;
      mem_busy    = $urandom_range(0, 3) == 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
